// File: rtl/spectrum_bar_writer.sv
// Pops packed multi-channel samples from a FIFO, tracks the per-column peak magnitude,
// quantises it to a bar height and writes it to display RAM at an auto-wrapping column address.
module spectrum_bar_writer #(
   parameter int SAMPLE_W        = 32,
   parameter int CHANNELS        = 2,
   parameter int DATA_W          = 6,
   parameter int ADDR_W          = 6,
   parameter int NUM_COLS        = 64,
   parameter int SAMPLES_PER_COL = 16
) (
   input  logic                clk_clk,
   input  logic                reset_reset_n,
   input  logic                enable,
   input  logic                mode_decay,
   input  logic                clear_overflow,
   input  logic [SAMPLE_W-1:0] fifo_q,
   input  logic                fifo_rdempty,
   input  logic                fifo_rdfull,
   output logic                fifo_rdreq,
   output logic [DATA_W-1:0]   ram_data,
   output logic [ADDR_W-1:0]   ram_wraddress,
   output logic                ram_wren,
   output logic                frame_done,
   output logic                overflow
);

   localparam int FIELD_W = SAMPLE_W / CHANNELS;
   localparam int MAG_W   = FIELD_W - 1;
   localparam int CNT_W   = (SAMPLES_PER_COL > 1) ? $clog2(SAMPLES_PER_COL) : 1;

   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SAMPLES_PER_COL - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_COLS - 1);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_REQ     = 2'd1;
   localparam logic [1:0] ST_CAPTURE = 2'd2;
   localparam logic [1:0] ST_WRITE   = 2'd3;

   logic [1:0]          state_reg, state_next;
   logic [CNT_W-1:0]    sample_cnt_reg;
   logic [MAG_W-1:0]    peak_reg, peak_next;
   logic [ADDR_W-1:0]   col_addr_reg;
   logic [NUM_COLS-1:0] col_valid_reg;
   logic [DATA_W-1:0]   ram_data_reg;
   logic [ADDR_W-1:0]   ram_wraddress_reg;
   logic                ram_wren_reg;
   logic                frame_done_reg;
   logic                overflow_reg;

   logic [DATA_W-1:0]   shadow_mem [NUM_COLS];
   logic [DATA_W-1:0]   shadow_rd_reg;

   logic [MAG_W-1:0]    field_mag [CHANNELS];
   logic [MAG_W-1:0]    word_mag;
   logic [DATA_W-1:0]   quant;
   logic [DATA_W-1:0]   shadow_prev;
   logic [DATA_W-1:0]   shadow_dec;
   logic [DATA_W-1:0]   bar;

   // Magnitude per signed field; negating the most negative value leaves the sign bit set,
   // which is used to saturate it to the largest positive magnitude.
   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_field
         logic [FIELD_W-1:0] field;
         logic [FIELD_W-1:0] field_neg;
         assign field     = fifo_q[gi*FIELD_W +: FIELD_W];
         assign field_neg = -field;
         assign field_mag[gi] = !field[FIELD_W-1]    ? field[MAG_W-1:0] :
                                field_neg[FIELD_W-1] ? {MAG_W{1'b1}}    :
                                                       field_neg[MAG_W-1:0];
      end
   endgenerate

   always_comb begin
      word_mag = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (field_mag[i] > word_mag) begin
            word_mag = field_mag[i];
         end
      end
   end

   assign peak_next   = (word_mag > peak_reg) ? word_mag : peak_reg;
   assign quant       = peak_reg[MAG_W-1 -: DATA_W];
   assign shadow_prev = col_valid_reg[col_addr_reg] ? shadow_rd_reg : '0;
   assign shadow_dec  = (shadow_prev == '0) ? '0 : shadow_prev - 1'b1;
   assign bar         = (mode_decay && (shadow_dec > quant)) ? shadow_dec : quant;

   always_comb begin
      state_next = state_reg;
      fifo_rdreq = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (enable) begin
               state_next = ST_REQ;
            end
         end
         ST_REQ: begin
            if (!fifo_rdempty) begin
               fifo_rdreq = 1'b1;
               state_next = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            state_next = (sample_cnt_reg == CNT_LAST) ? ST_WRITE : ST_REQ;
         end
         ST_WRITE: begin
            state_next = enable ? ST_REQ : ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_reg         <= ST_IDLE;
         sample_cnt_reg    <= '0;
         peak_reg          <= '0;
         col_addr_reg      <= '0;
         col_valid_reg     <= '0;
         ram_data_reg      <= '0;
         ram_wraddress_reg <= '0;
         ram_wren_reg      <= 1'b0;
         frame_done_reg    <= 1'b0;
         overflow_reg      <= 1'b0;
      end else begin
         state_reg      <= state_next;
         ram_wren_reg   <= 1'b0;
         frame_done_reg <= ram_wren_reg && (ram_wraddress_reg == ADDR_LAST);

         if (fifo_rdfull) begin
            overflow_reg <= 1'b1;
         end else if (clear_overflow) begin
            overflow_reg <= 1'b0;
         end

         case (state_reg)
            ST_CAPTURE: begin
               peak_reg       <= peak_next;
               sample_cnt_reg <= sample_cnt_reg + 1'b1;
            end
            ST_WRITE: begin
               ram_data_reg                <= bar;
               ram_wraddress_reg           <= col_addr_reg;
               ram_wren_reg                <= 1'b1;
               col_valid_reg[col_addr_reg] <= 1'b1;
               peak_reg                    <= '0;
               sample_cnt_reg              <= '0;
               col_addr_reg <= (col_addr_reg == ADDR_LAST) ? '0 : col_addr_reg + 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   // Shadow heights live in RAM; the address is stable for a whole column, so the
   // registered read is current by the time the column reaches WRITE.
   always_ff @(posedge clk_clk) begin
      if (state_reg == ST_WRITE) begin
         shadow_mem[col_addr_reg] <= bar;
      end
      shadow_rd_reg <= shadow_mem[col_addr_reg];
   end

   assign ram_data      = ram_data_reg;
   assign ram_wraddress = ram_wraddress_reg;
   assign ram_wren      = ram_wren_reg;
   assign frame_done    = frame_done_reg;
   assign overflow      = overflow_reg;

endmodule
